// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file geometry and writeback request types shared by the writeback arbiter.
package regfile_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;
    localparam logic [RF_DATA_W-1:0] ZERO_VALUE = '0;
endpackage

// File: rtl/wb_slot.sv
// wb_slot: 1-entry writeback holding register; drains on grant and refills in the same cycle.
module wb_slot
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              take;

    // ready depends only on slot state, grant and flush -- never on in_valid
    always_comb begin
        in_ready = !flush && (!full_q || grant);
        take     = in_valid && in_ready;
        full_d   = flush ? 1'b0 : take ? 1'b1 : grant ? 1'b0 : full_q;
        addr_d   = take ? in_addr : addr_q;
        data_d   = take ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: two-port round-robin writeback arbiter feeding a registered register-file write stage.
// Define REG_WB_ZERO_PROTECT_EN to suppress rf_wena for writes to register 0.
module reg_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        pend_valid,
    output logic [ADDR_W-1:0] pend_addr0,
    output logic [ADDR_W-1:0] pend_addr1
);
    logic [1:0]        full, grant;
    logic [ADDR_W-1:0] addr0, addr1, sel_addr;
    logic [DATA_W-1:0] data0, data1, sel_data;
    logic              rr_q, rr_d;
    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(wb0_valid), .in_ready(wb0_ready), .in_addr(wb0_addr), .in_data(wb0_data),
        .grant(grant[0]), .full(full[0]), .addr(addr0), .data(data0)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(wb1_valid), .in_ready(wb1_ready), .in_addr(wb1_addr), .in_data(wb1_data),
        .grant(grant[1]), .full(full[1]), .addr(addr1), .data(data1)
    );

    // rr_q names the slot that wins when both are full; only contested grants move it
    always_comb begin
        grant[0] = !flush && full[0] && (!full[1] || !rr_q);
        grant[1] = !flush && full[1] && (!full[0] || rr_q);
        rr_d     = (!flush && &full) ? !rr_q : rr_q;
        sel_addr = grant[1] ? addr1 : addr0;
        sel_data = grant[1] ? data1 : data0;
`ifdef REG_WB_ZERO_PROTECT_EN
        wena_d   = |grant && (sel_addr != '0);
`else
        wena_d   = |grant;
`endif
        waddr_d  = |grant ? sel_addr : waddr_q;
        wdata_d  = |grant ? sel_data : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            wena_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wena_q  <= wena_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_wena    = wena_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign pend_valid = full;
    assign pend_addr0 = addr0;
    assign pend_addr1 = addr1;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: scoreboard bench for reg_wb_arbiter; per-port expected-write queues.
module tb_reg_wb_arbiter;
    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic        wb0_ready, wb1_ready;
    logic [3:0]  wb0_addr = '0, wb1_addr = '0;
    logic [31:0] wb0_data = '0, wb1_data = '0;
    logic        rf_wena;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  pend_valid;
    logic [3:0]  pend_addr0, pend_addr1;

    wr_t q0[$], q1[$];
    int  n_chk = 0, n_err = 0, n_wr = 0;

    reg_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_valid(pend_valid), .pend_addr0(pend_addr0), .pend_addr1(pend_addr1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] a, input logic [31:0] d);
        wb0_valid = v; wb0_addr = a; wb0_data = d;
    endtask

    task automatic drive1(input logic v, input logic [3:0] a, input logic [31:0] d);
        wb1_valid = v; wb1_addr = a; wb1_data = d;
    endtask

    // each register-file write must match the head of one port's queue
    always @(negedge clk) begin
        wr_t w, e;
        if (rst_n && rf_wena) begin
            n_wr++;
            w = {rf_waddr, rf_wdata};
            if (q0.size() != 0 && q0[0] == w) e = q0.pop_front();
            else if (q1.size() != 0) e = q1.pop_front();
            else if (q0.size() != 0) e = q0.pop_front();
            else e = 'x;
            chk("rf_write", 64'(w), 64'(e));
        end
    end

    initial begin
        int  n0, n1, rc0, rc1, base;
        logic f0, f1;
        step();
        chk("rst_wena", rf_wena, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_pend", pend_valid, 0);
        chk("rst_paddr0", pend_addr0, 0);
        chk("rst_paddr1", pend_addr1, 0);
        step();
        rst_n = 1'b1;
        chk("rst_rdy0", wb0_ready, 1);
        chk("rst_rdy1", wb1_ready, 1);

        // single ALU write: two-cycle latency, one-cycle pulse
        drive0(1, 4'd3, 32'hDEADBEEF);
        q0.push_back('{4'd3, 32'hDEADBEEF});
        step();
        drive0(0, 0, 0);
        chk("t1_pend", pend_valid, 2'b01);
        chk("t1_wena_early", rf_wena, 0);
        step();
        chk("t1_wena", rf_wena, 1);
        chk("t1_waddr", rf_waddr, 3);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("t1_wena_off", rf_wena, 0);

        // contention with rr=0, then the next conflict favours port 1
        drive0(1, 4'd1, 32'h11); drive1(1, 4'd2, 32'h22);
        q0.push_back('{4'd1, 32'h11}); q1.push_back('{4'd2, 32'h22});
        step();
        drive0(0, 0, 0); drive1(0, 0, 0);
        chk("t2_pend", pend_valid, 2'b11);
        chk("t2_paddr0", pend_addr0, 1);
        chk("t2_paddr1", pend_addr1, 2);
        step();
        chk("t2_first", rf_waddr, 1);
        step();
        chk("t2_second", rf_waddr, 2);
        chk("t2_second_en", rf_wena, 1);
        drive0(1, 4'd5, 32'h55); drive1(1, 4'd6, 32'h66);
        q0.push_back('{4'd5, 32'h55}); q1.push_back('{4'd6, 32'h66});
        step();
        drive0(0, 0, 0); drive1(0, 0, 0);
        step();
        chk("t2_rr_first", rf_waddr, 6);
        step();
        chk("t2_rr_second", rf_waddr, 5);
        step();
        chk("t2_idle", rf_wena, 0);

        // port 0 streaming alone
        base = n_wr;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                drive0(1, 4'(i + 1), 32'h100 + i);
                q0.push_back('{4'(i + 1), 32'h100 + i});
                chk("t3_ready", wb0_ready, 1);
            end else drive0(0, 0, 0);
            if (i >= 2) chk("t3_wena", rf_wena, 1);
            step();
        end
        step();
        chk("t3_pulses", n_wr - base, 8);

        // both ports streaming: readies alternate, one write every cycle
        n0 = 0; n1 = 0; rc0 = 0; rc1 = 0;
        drive0(1, 4'(1 + n0 % 7), 32'hA000_0000 + n0);
        drive1(1, 4'(8 + n1 % 8), 32'hB000_0000 + n1);
        for (int i = 0; i < 17; i++) begin
            f0 = wb0_ready; f1 = wb1_ready;
            if (i >= 1) begin
                rc0 += int'(f0); rc1 += int'(f1);
                chk("t4_alt", f0 ^ f1, 1);
            end
            if (i >= 2) chk("t4_wena", rf_wena, 1);
            if (f0) q0.push_back('{4'(1 + n0 % 7), 32'hA000_0000 + n0});
            if (f1) q1.push_back('{4'(8 + n1 % 8), 32'hB000_0000 + n1});
            step();
            if (f0) n0++;
            if (f1) n1++;
            drive0(1, 4'(1 + n0 % 7), 32'hA000_0000 + n0);
            drive1(1, 4'(8 + n1 % 8), 32'hB000_0000 + n1);
        end
        drive0(0, 0, 0); drive1(0, 0, 0);
        chk("t4_duty0", rc0, 8);
        chk("t4_duty1", rc1, 8);
        repeat (4) step();

        // flush with both slots full and a write already in the write stage
        drive0(1, 4'd7, 32'h77);
        q0.push_back('{4'd7, 32'h77});
        step();
        chk("t5_pend1", pend_valid, 2'b01);
        drive0(1, 4'd9, 32'h99); drive1(1, 4'd10, 32'hAA);
        step();
        drive0(0, 0, 0); drive1(0, 0, 0);
        chk("t5_pend2", pend_valid, 2'b11);
        flush = 1'b1;
        #1;
        chk("t5_rdy0", wb0_ready, 0);
        chk("t5_rdy1", wb1_ready, 0);
        chk("t5_stage_en", rf_wena, 1);
        chk("t5_stage_addr", rf_waddr, 7);
        step();
        flush = 1'b0;
        chk("t5_pend0", pend_valid, 0);
        chk("t5_no_wena", rf_wena, 0);
        step();
        chk("t5_no_wena2", rf_wena, 0);

        // asynchronous reset with everything in flight
        drive0(1, 4'd11, 32'hB1);
        step();
        drive0(1, 4'd12, 32'hB2); drive1(1, 4'd13, 32'hB3);
        step();
        drive0(0, 0, 0); drive1(0, 0, 0);
        chk("t6_pre_wena", rf_wena, 1);
        chk("t6_pre_pend", pend_valid, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("t6_wena", rf_wena, 0);
        chk("t6_waddr", rf_waddr, 0);
        chk("t6_wdata", rf_wdata, 0);
        chk("t6_pend", pend_valid, 0);
        chk("t6_paddr1", pend_addr1, 0);
        step();
        rst_n = 1'b1;

        // register 0 write, then a normal write
        drive0(1, 4'd0, 32'h5A);
`ifdef REG_WB_ZERO_PROTECT_EN
        step();
        drive0(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t6_zero_wena", rf_wena, 0);
            step();
        end
`else
        q0.push_back('{4'd0, 32'h5A});
        step();
        drive0(0, 0, 0);
        step();
        chk("t6_zero_wena", rf_wena, 1);
        chk("t6_zero_addr", rf_waddr, 0);
        step();
`endif
        drive1(1, 4'd4, 32'h44);
        q1.push_back('{4'd4, 32'h44});
        step();
        drive1(0, 0, 0);
        step();
        chk("t6_after_addr", rf_waddr, 4);
        repeat (4) step();
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
